// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and any matching deserializer:
// FSM state encodings and an even-parity helper.
package piso_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int unsigned MAX_WIDTH = 32;

  // Even-parity bit for a word zero-extended to MAX_WIDTH bits.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with ready/load handshake, optional even
// parity bit after the data bits and a one-cycle done pulse at frame end.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW   = $clog2(WIDTH + 2);
  localparam int unsigned LAST = WIDTH - 1 + ((PARITY_EN != 0) ? 1 : 0);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             par, par_nxt;
  logic             sout_nxt;

  // Bit that leaves the word next, in the configured order.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // State and datapath registers; status outputs follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      par        <= par_nxt;
      sout       <= sout_nxt;
      sout_valid <= (state_nxt == SHIFT);
      ready      <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

  // cnt holds the index of the bit currently on sout while in SHIFT.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par;
    sout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sout_nxt  = head(D);
          shreg_nxt = advance(D);
          par_nxt   = even_parity(MAX_WIDTH'(D));
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(LAST)) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sout_nxt = par;
          end else begin
            sout_nxt  = head(shreg);
            shreg_nxt = advance(shreg);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer configurations driven from a vector
// table, hand-written corner sequences and a queue-based random model.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] d    [3];
  logic       ld   [3];
  logic       rdy  [3];
  logic       so   [3];
  logic       sv   [3];
  logic       bsy  [3];
  logic       dn   [3];

  int n_cmp = 0;
  int n_err = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(reset), .D(d[0]), .load(ld[0]), .ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bsy[0]), .done(dn[0]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .D(d[1]), .load(ld[1]), .ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bsy[1]), .done(dn[1]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .D(d[2]), .load(ld[2]), .ready(rdy[2]),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [7:0] dv;
    logic [8:0] bits;   // expected serial stream, first bit at bits[n-1]
    int         n;
    bit         chg;    // change D right after acceptance
    bit         noise;  // toggle load during SHIFT/DONE
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input int inst, input string tag, input logic s, input logic v,
                           input logic r, input logic b, input logic dd);
    chk($sformatf("u%0d %s sout", inst, tag), 32'(so[inst]), 32'(s));
    chk($sformatf("u%0d %s sout_valid", inst, tag), 32'(sv[inst]), 32'(v));
    chk($sformatf("u%0d %s ready", inst, tag), 32'(rdy[inst]), 32'(r));
    chk($sformatf("u%0d %s busy", inst, tag), 32'(bsy[inst]), 32'(b));
    chk($sformatf("u%0d %s done", inst, tag), 32'(dn[inst]), 32'(dd));
  endtask

  // One frame from IDLE: accept, n bits, done, back to idle with no extra frame.
  task automatic run_frame(input int inst, input logic [7:0] dv, input logic [8:0] bits,
                           input int n, input bit chg, input bit noise);
    d[inst]  = dv;
    ld[inst] = 1'b1;
    tick();
    ld[inst] = noise;
    if (chg) d[inst] = 8'h00;
    for (int i = 0; i < n; i++) begin
      check_out(inst, $sformatf("d%0h bit%0d", dv, i), bits[n-1-i], 1'b1, 1'b0, 1'b1, 1'b0);
      if (noise) ld[inst] = ~ld[inst];
      tick();
    end
    check_out(inst, $sformatf("d%0h done", dv), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_out(inst, $sformatf("d%0h ready", dv), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ld[inst] = 1'b0;
    tick();
    check_out(inst, $sformatf("d%0h idle", dv), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Random load/D against a queue of expected serial bits.
  task automatic rand_run(input int inst, input bit msb, input bit par, input int cycles);
    bit         q[$];
    logic       e_s, e_v, e_r, e_b, e_d, l;
    logic [7:0] dv;
    e_s = 0; e_v = 0; e_r = 1; e_b = 0; e_d = 0;
    for (int c = 0; c < cycles; c++) begin
      l  = (c < cycles - 14) && ($urandom_range(0, 2) == 0);
      dv = 8'($urandom);
      d[inst]  = dv;
      ld[inst] = l;
      if (e_r && l) begin
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(msb ? dv[7-i] : dv[i]);
        if (par) q.push_back(($countones(dv) % 2) == 1);
        e_s = q.pop_front(); e_v = 1; e_r = 0; e_b = 1; e_d = 0;
      end else if (e_v) begin
        if (q.size() > 0) e_s = q.pop_front();
        else begin e_s = 0; e_v = 0; e_d = 1; end
      end else if (e_d) begin
        e_d = 0; e_r = 1; e_b = 0;
      end
      tick();
      check_out(inst, $sformatf("rand c%0d", c), e_s, e_v, e_r, e_b, e_d);
    end
    ld[inst] = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 8'hAA, 9'h0AA, 8, 1'b0, 1'b0};
    tbl[1] = '{0, 8'hCC, 9'h0CC, 8, 1'b1, 1'b1};
    tbl[2] = '{1, 8'hFF, 9'h1FE, 9, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h01, 9'h003, 9, 1'b0, 1'b1};
    tbl[4] = '{2, 8'h0F, 9'h0F0, 8, 1'b0, 1'b0};
    tbl[5] = '{0, 8'h5A, 9'h05A, 8, 1'b1, 1'b0};
    tbl[6] = '{2, 8'hA5, 9'h0A5, 8, 1'b0, 1'b1};
    tbl[7] = '{1, 8'h03, 9'h006, 9, 1'b1, 1'b0};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i]  = 8'h00;
      ld[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) check_out(i, "reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Load on the first edge after reset release, then the rest of the table.
    for (int k = 0; k < 8; k++)
      run_frame(tbl[k].inst, tbl[k].dv, tbl[k].bits, tbl[k].n, tbl[k].chg, tbl[k].noise);

    // Load held high: a new 5A frame every 10 cycles.
    d[0]  = 8'h5A;
    ld[0] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        check_out(0, $sformatf("held f%0d bit%0d", f, i), d[0][7-i], 1'b1, 1'b0, 1'b1, 1'b0);
      end
      tick();
      check_out(0, $sformatf("held f%0d done", f), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check_out(0, $sformatf("held f%0d ready", f), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    ld[0] = 1'b0;
    tick();
    check_out(0, "held stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during the 4th bit of an AA frame aborts it with no done pulse.
    d[0]  = 8'hAA;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    tick();
    tick();
    tick();
    check_out(0, "pre-reset bit3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out(0, "async reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out(0, $sformatf("in reset %0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    check_out(0, "post reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(0, 8'h0F, 9'h00F, 8, 1'b0, 1'b0);

    rand_run(0, 1'b1, 1'b0, 250);
    rand_run(1, 1'b1, 1'b1, 250);
    rand_run(2, 1'b0, 1'b0, 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
